shot_clock_ctrl: RTL and testbench

Per-turn shot-clock controller for the billiard game. Consumes the one-pulse-per-second tick from the slow-clock counter and drives its turbo select. Sequences the turn countdown, freezes it while balls are rolling, and rotates the active player on timeout or end of shot. Sits between the game-control FSM (shot/ball-motion events) and the display/score logic (seconds left, warning, player index).

---
 rtl/shot_clock_ctrl.sv | 156 +++++++++++++++
 tb/tb_shot_clock_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_clock_ctrl.sv
// Shot-clock controller: per-turn countdown that freezes while balls roll,
// holds on pause, and rotates the active player on expiry or end of shot.
// Consumes the slow-clock one-second tick and drives its turbo select.
module shot_clock_ctrl #(
    parameter int TURN_SECONDS = 30,
    parameter int WARN_SECONDS = 5,
    parameter int NUM_PLAYERS  = 2,
    parameter int SEC_W        = 7
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             game_en,
    input  logic             start_game,
    input  logic             one_sec,
    input  logic             turbo_req,
    input  logic             pause,
    input  logic             shot_taken,
    input  logic             balls_moving,
    input  logic             keep_turn,
    output logic             turbo,
    output logic [SEC_W-1:0] seconds_left,
    output logic [1:0]       player,
    output logic             warn,
    output logic             timeout,
    output logic             turn_start,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUNNING = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_FROZEN  = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;

    localparam logic [SEC_W-1:0] TURN_VAL    = SEC_W'(TURN_SECONDS);
    localparam logic [SEC_W-1:0] WARN_VAL    = SEC_W'(WARN_SECONDS);
    localparam logic [SEC_W-1:0] ONE_SEC     = SEC_W'(1);
    localparam logic [1:0]       LAST_PLAYER = 2'(NUM_PLAYERS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [SEC_W-1:0] sec_d;
    logic [1:0]       player_d;
    logic             timeout_d;
    logic             turn_start_d;
    logic             warn_d;
    logic             turbo_d;
    logic [1:0]       player_adv;

    // Next player in rotation, wrapping after the last one.
    assign player_adv = (player == LAST_PLAYER) ? 2'd0 : player + 2'd1;
    assign state      = state_q;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        sec_d        = seconds_left;
        player_d     = player;
        timeout_d    = 1'b0;
        turn_start_d = 1'b0;

        if (!game_en) begin
            state_d  = ST_IDLE;
            sec_d    = '0;
            player_d = 2'd0;
        end else if (start_game) begin
            state_d      = ST_RUNNING;
            sec_d        = TURN_VAL;
            player_d     = 2'd0;
            turn_start_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    sec_d    = '0;
                    player_d = 2'd0;
                end
                ST_RUNNING: begin
                    // pause beats a shot, a shot beats the tick.
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (shot_taken) begin
                        state_d = ST_FROZEN;
                    end else if (one_sec) begin
                        if (seconds_left > ONE_SEC) begin
                            sec_d = seconds_left - ONE_SEC;
                        end else begin
                            sec_d     = '0;
                            state_d   = ST_EXPIRED;
                            timeout_d = 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_FROZEN: begin
                    // Entry already costs one cycle here, so the first edge
                    // in FROZEN may exit once the table is still.
                    if (!balls_moving) begin
                        state_d      = ST_RUNNING;
                        sec_d        = TURN_VAL;
                        turn_start_d = 1'b1;
                        if (!keep_turn) begin
                            player_d = player_adv;
                        end
                    end
                end
                ST_EXPIRED: begin
                    state_d      = ST_RUNNING;
                    sec_d        = TURN_VAL;
                    player_d     = player_adv;
                    turn_start_d = 1'b1;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sec_d    = '0;
                    player_d = 2'd0;
                end
            endcase
        end

        warn_d  = ((state_d == ST_RUNNING) || (state_d == ST_PAUSED)) &&
                  (sec_d != '0) && (sec_d <= WARN_VAL);
        turbo_d = (state_d != ST_IDLE) && turbo_req;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            seconds_left <= '0;
            player       <= 2'd0;
            turbo        <= 1'b0;
            warn         <= 1'b0;
            timeout      <= 1'b0;
            turn_start   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            seconds_left <= sec_d;
            player       <= player_d;
            turbo        <= turbo_d;
            warn         <= warn_d;
            timeout      <= timeout_d;
            turn_start   <= turn_start_d;
        end
    end

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Self-checking bench for shot_clock_ctrl: directed scenarios followed by a
// randomized run compared cycle by cycle against a behavioural model.
module tb_shot_clock_ctrl;

    localparam int TURN = 5;
    localparam int WARN = 2;
    localparam int NP   = 3;
    localparam int SW   = 7;

    localparam int IDLE = 0;
    localparam int RUN  = 1;
    localparam int PAU  = 2;
    localparam int FRZ  = 3;
    localparam int EXP  = 4;

    logic          clk          = 1'b0;
    logic          resetN       = 1'b0;
    logic          game_en      = 1'b0;
    logic          start_game   = 1'b0;
    logic          one_sec      = 1'b0;
    logic          turbo_req    = 1'b0;
    logic          pause        = 1'b0;
    logic          shot_taken   = 1'b0;
    logic          balls_moving = 1'b0;
    logic          keep_turn    = 1'b0;
    logic          turbo;
    logic [SW-1:0] seconds_left;
    logic [1:0]    player;
    logic          warn;
    logic          timeout;
    logic          turn_start;
    logic [2:0]    state;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model of the visible outputs.
    int m_st  = IDLE;
    int m_sec = 0;
    int m_ply = 0;
    bit m_turbo = 1'b0;
    bit m_warn  = 1'b0;
    bit m_to    = 1'b0;
    bit m_ts    = 1'b0;

    shot_clock_ctrl #(
        .TURN_SECONDS(TURN),
        .WARN_SECONDS(WARN),
        .NUM_PLAYERS (NP),
        .SEC_W       (SW)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .game_en     (game_en),
        .start_game  (start_game),
        .one_sec     (one_sec),
        .turbo_req   (turbo_req),
        .pause       (pause),
        .shot_taken  (shot_taken),
        .balls_moving(balls_moving),
        .keep_turn   (keep_turn),
        .turbo       (turbo),
        .seconds_left(seconds_left),
        .player      (player),
        .warn        (warn),
        .timeout     (timeout),
        .turn_start  (turn_start),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the turn rules directly.
    task automatic model_step();
        int st;
        int sec;
        int ply;
        bit to;
        bit ts;
        st  = m_st;
        sec = m_sec;
        ply = m_ply;
        to  = 1'b0;
        ts  = 1'b0;
        if (!resetN || !game_en) begin
            st  = IDLE;
            sec = 0;
            ply = 0;
        end else if (start_game) begin
            st  = RUN;
            sec = TURN;
            ply = 0;
            ts  = 1'b1;
        end else begin
            case (m_st)
                RUN: begin
                    if (pause) st = PAU;
                    else if (shot_taken) st = FRZ;
                    else if (one_sec) begin
                        sec = sec - 1;
                        if (sec == 0) begin
                            st = EXP;
                            to = 1'b1;
                        end
                    end
                end
                PAU: if (!pause) st = RUN;
                FRZ: begin
                    if (!balls_moving) begin
                        st  = RUN;
                        sec = TURN;
                        ts  = 1'b1;
                        if (!keep_turn) ply = (ply + 1) % NP;
                    end
                end
                EXP: begin
                    st  = RUN;
                    sec = TURN;
                    ts  = 1'b1;
                    ply = (ply + 1) % NP;
                end
                default: ;
            endcase
        end
        m_st    = st;
        m_sec   = sec;
        m_ply   = ply;
        m_to    = to;
        m_ts    = ts;
        m_turbo = resetN && (st != IDLE) && turbo_req;
        m_warn  = (st == RUN || st == PAU) && sec >= 1 && sec <= WARN;
    endtask

    // One clock: model follows the edge, outputs settle, pulses drop.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        start_game = 1'b0;
        one_sec    = 1'b0;
        shot_taken = 1'b0;
    endtask

    task automatic test_reset();
        resetN  = 1'b0;
        game_en = 1'b0;
        #2;
        n_total++;
        if (state !== 3'd0 || seconds_left !== '0 || player !== 2'd0)
            $display("FAIL reset_regs: got st=%0d sec=%0d ply=%0d want 0/0/0", state, seconds_left, player);
        else n_pass++;
        n_total++;
        if (turbo !== 1'b0 || warn !== 1'b0 || timeout !== 1'b0 || turn_start !== 1'b0)
            $display("FAIL reset_flags: got turbo=%b warn=%b to=%b ts=%b want 0000", turbo, warn, timeout, turn_start);
        else n_pass++;
        tick();
        tick();
        @(negedge clk);
        resetN  = 1'b1;
        game_en = 1'b1;
        tick();
        n_total++;
        if (state !== 3'(IDLE) || seconds_left !== '0)
            $display("FAIL idle_after_reset: got st=%0d sec=%0d want 0/0", state, seconds_left);
        else n_pass++;
    endtask

    task automatic test_countdown();
        int n_to;
        n_to = 0;
        start_game = 1'b1;
        tick();
        n_total++;
        if (state !== 3'(RUN) || seconds_left !== SW'(TURN) || turn_start !== 1'b1 || player !== 2'd0 || warn !== 1'b0)
            $display("FAIL start: got st=%0d sec=%0d ts=%b ply=%0d warn=%b want 1/5/1/0/0", state, seconds_left, turn_start, player, warn);
        else n_pass++;
        for (int k = TURN - 1; k >= 0; k--) begin
            one_sec = 1'b1;
            tick();
            n_to += int'(timeout);
            n_total++;
            if (seconds_left !== SW'(k) || warn !== (k == 1 || k == 2))
                $display("FAIL countdown: got sec=%0d warn=%b want sec=%0d warn=%b", seconds_left, warn, k, (k == 1 || k == 2));
            else n_pass++;
            n_total++;
            if (state !== 3'(k == 0 ? EXP : RUN) || timeout !== (k == 0))
                $display("FAIL countdown_state: got st=%0d to=%b want st=%0d to=%b", state, timeout, (k == 0 ? EXP : RUN), (k == 0));
            else n_pass++;
        end
        tick();
        n_to += int'(timeout);
        n_total++;
        if (state !== 3'(RUN) || player !== 2'd1 || seconds_left !== SW'(TURN) || turn_start !== 1'b1 || n_to != 1)
            $display("FAIL expiry_reload: got st=%0d ply=%0d sec=%0d ts=%b timeouts=%0d want 1/1/5/1/1", state, player, seconds_left, turn_start, n_to);
        else n_pass++;
    endtask

    task automatic test_pause();
        one_sec = 1'b1;
        tick();
        pause = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            one_sec = 1'b1;
            tick();
            n_total++;
            if (state !== 3'(PAU) || seconds_left !== SW'(4))
                $display("FAIL paused_hold: got st=%0d sec=%0d want 2/4", state, seconds_left);
            else n_pass++;
        end
        pause = 1'b0;
        tick();
        n_total++;
        if (state !== 3'(RUN) || seconds_left !== SW'(4))
            $display("FAIL pause_release: got st=%0d sec=%0d want 1/4", state, seconds_left);
        else n_pass++;
        one_sec = 1'b1;
        tick();
        n_total++;
        if (seconds_left !== SW'(3))
            $display("FAIL tick_after_pause: got sec=%0d want 3", seconds_left);
        else n_pass++;
    endtask

    task automatic test_frozen();
        shot_taken = 1'b1;
        one_sec    = 1'b1;
        tick();
        n_total++;
        if (state !== 3'(FRZ) || seconds_left !== SW'(3))
            $display("FAIL shot_vs_tick: got st=%0d sec=%0d want 3/3", state, seconds_left);
        else n_pass++;
        balls_moving = 1'b1;
        for (int i = 0; i < 10; i++) begin
            one_sec = 1'b1;
            pause   = i[0];
            tick();
            n_total++;
            if (state !== 3'(FRZ) || seconds_left !== SW'(3))
                $display("FAIL frozen_hold: got st=%0d sec=%0d want 3/3", state, seconds_left);
            else n_pass++;
        end
        pause        = 1'b0;
        balls_moving = 1'b0;
        keep_turn    = 1'b1;
        tick();
        n_total++;
        if (state !== 3'(RUN) || player !== 2'd1 || seconds_left !== SW'(TURN) || turn_start !== 1'b1 || timeout !== 1'b0)
            $display("FAIL keep_turn_exit: got st=%0d ply=%0d sec=%0d ts=%b to=%b want 1/1/5/1/0", state, player, seconds_left, turn_start, timeout);
        else n_pass++;
        keep_turn  = 1'b0;
        shot_taken = 1'b1;
        tick();
        n_total++;
        if (state !== 3'(FRZ))
            $display("FAIL frozen_min_cycle: got st=%0d want 3", state);
        else n_pass++;
        tick();
        n_total++;
        if (state !== 3'(RUN) || player !== 2'd2)
            $display("FAIL pass_turn_exit: got st=%0d ply=%0d want 1/2", state, player);
        else n_pass++;
    endtask

    task automatic test_player_wrap();
        start_game = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < TURN; k++) begin
                one_sec = 1'b1;
                tick();
            end
            n_total++;
            if (state !== 3'(EXP) || timeout !== 1'b1)
                $display("FAIL wrap_expired: got st=%0d to=%b want 4/1", state, timeout);
            else n_pass++;
            tick();
            n_total++;
            if (player !== 2'((i + 1) % NP))
                $display("FAIL wrap_player: got ply=%0d want %0d", player, (i + 1) % NP);
            else n_pass++;
        end
    endtask

    task automatic test_game_en_drop();
        start_game = 1'b1;
        tick();
        shot_taken = 1'b1;
        tick();
        tick();
        balls_moving = 1'b1;
        shot_taken   = 1'b1;
        tick();
        turbo_req = 1'b1;
        tick();
        n_total++;
        if (state !== 3'(FRZ) || player !== 2'd1 || turbo !== 1'b1)
            $display("FAIL pre_drop: got st=%0d ply=%0d turbo=%b want 3/1/1", state, player, turbo);
        else n_pass++;
        game_en = 1'b0;
        tick();
        n_total++;
        if (state !== 3'(IDLE) || seconds_left !== '0 || player !== 2'd0 || turbo !== 1'b0)
            $display("FAIL game_en_drop: got st=%0d sec=%0d ply=%0d turbo=%b want 0/0/0/0", state, seconds_left, player, turbo);
        else n_pass++;
        game_en      = 1'b1;
        balls_moving = 1'b0;
        turbo_req    = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        start_game = 1'b1;
        turbo_req  = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            one_sec = 1'b1;
            tick();
        end
        n_total++;
        if (seconds_left !== SW'(2) || warn !== 1'b1 || turbo !== 1'b1)
            $display("FAIL pre_reset: got sec=%0d warn=%b turbo=%b want 2/1/1", seconds_left, warn, turbo);
        else n_pass++;
        #2;
        resetN = 1'b0;
        #1;
        n_total++;
        if (state !== 3'd0 || seconds_left !== '0 || player !== 2'd0 || turbo !== 1'b0 ||
            warn !== 1'b0 || timeout !== 1'b0 || turn_start !== 1'b0)
            $display("FAIL async_reset: got st=%0d sec=%0d ply=%0d turbo=%b warn=%b to=%b ts=%b want all 0",
                     state, seconds_left, player, turbo, warn, timeout, turn_start);
        else n_pass++;
        m_st = IDLE; m_sec = 0; m_ply = 0;
        m_turbo = 1'b0; m_warn = 1'b0; m_to = 1'b0; m_ts = 1'b0;
        tick();
        @(negedge clk);
        resetN    = 1'b1;
        turbo_req = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            game_en    = ($urandom_range(0, 63) != 0);
            start_game = ($urandom_range(0, 39) == 0);
            one_sec    = ($urandom_range(0, 2) == 0);
            shot_taken = ($urandom_range(0, 19) == 0);
            keep_turn  = $urandom_range(0, 1) == 1;
            turbo_req  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            if ($urandom_range(0, 3) == 0) balls_moving = ~balls_moving;
            tick();
            n_total++;
            if (state !== 3'(m_st) || seconds_left !== SW'(m_sec) || player !== 2'(m_ply) ||
                turbo !== m_turbo || warn !== m_warn || timeout !== m_to || turn_start !== m_ts)
                $display("FAIL random cyc %0d: got st=%0d sec=%0d ply=%0d tb=%b w=%b to=%b ts=%b want st=%0d sec=%0d ply=%0d tb=%b w=%b to=%b ts=%b",
                         c, state, seconds_left, player, turbo, warn, timeout, turn_start,
                         m_st, m_sec, m_ply, m_turbo, m_warn, m_to, m_ts);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_frozen();
        test_player_wrap();
        test_game_en_drop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
